// File: rtl/isq_pkg.sv
// Shared constants and line layout for the instruction scheduling queue.
// Used by the line write path and the issue-side reader.
package isq_pkg;

  localparam int INST_WIDTH     = 14;
  localparam int ISQ_LINE_WIDTH = INST_WIDTH + 2;
  localparam int VAL_BIT        = ISQ_LINE_WIDTH - 1;
  localparam int WAT_BIT        = ISQ_LINE_WIDTH - 2;

  typedef struct packed {
    logic                  val;
    logic                  wat;
    logic [INST_WIDTH-1:0] inst;
  } isq_line_t;

endpackage

// File: rtl/isq_pick.sv
// Rotating priority encoder: first set request at or after i_ptr,
// wrapping modulo DEPTH.
module isq_pick #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_k;

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    o_idx = '0;
    w_k   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_k = i_ptr + IDX_W'(i);
      if (i_req[w_k]) o_idx = w_k;
    end
  end

  assign o_found = |i_req;

endmodule

// File: rtl/isq_iss.sv
// Issue-side reader: round-robin select of an issuable ISQ line into a
// single-entry output register with a valid/ready handshake.
module isq_iss #(
  parameter int INST_WIDTH     = isq_pkg::INST_WIDTH,
  parameter int DEPTH          = 8,
  parameter int ISQ_LINE_WIDTH = INST_WIDTH + 2,
  parameter int IDX_W          = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fls,
  input  logic [DEPTH*ISQ_LINE_WIDTH-1:0] isq_lines_in,
  output logic [DEPTH-1:0]                clr_val_out,
  output logic                            iss_vld,
  input  logic                            iss_rdy,
  output logic [INST_WIDTH-1:0]           iss_inst,
  output logic [IDX_W-1:0]                iss_idx,
  output logic [15:0]                     iss_cnt
);

  import isq_pkg::*;

  localparam int VB = ISQ_LINE_WIDTH - 1;
  localparam int WB = ISQ_LINE_WIDTH - 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]            r_state;
  logic [INST_WIDTH-1:0] r_inst;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic [15:0]           r_cnt;

  logic [ISQ_LINE_WIDTH-1:0] w_line [DEPTH];
  logic [DEPTH-1:0]          w_req;
  logic                      w_found;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_load;
  logic                      w_hs;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_line[k] = isq_lines_in[k*ISQ_LINE_WIDTH +: ISQ_LINE_WIDTH];
      w_req[k]  = w_line[k][VB] & ~w_line[k][WB];
    end
  end

  isq_pick #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_load = (r_state == S_IDLE || iss_rdy)
                & w_found & ~fls & ~rst;
  assign w_hs   = (r_state == S_FULL) & iss_rdy & ~fls;

  // The line drops val on the next edge, so it is never reselected.
  assign clr_val_out = w_load ? (DEPTH'(1) << w_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_inst  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_hs) r_cnt <= r_cnt + 16'd1;
      if (fls) begin
        r_state <= S_IDLE;
        r_ptr   <= '0;
      end else if (w_load) begin
        r_state <= S_FULL;
        r_inst  <= w_line[w_idx][INST_WIDTH-1:0];
        r_idx   <= w_idx;
        r_ptr   <= w_idx + IDX_W'(1);
      end else if (r_state == S_FULL && iss_rdy) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign iss_vld  = (r_state == S_FULL);
  assign iss_inst = r_inst;
  assign iss_idx  = r_idx;
  assign iss_cnt  = r_cnt;

endmodule

// File: tb/tb_isq_iss.sv
// Directed bench for isq_iss with a line-array model and an issue
// scoreboard checked by an independent monitor.
module tb_isq_iss;

  import isq_pkg::*;

  localparam int D  = 8;
  localparam int IW = 14;
  localparam int LW = 16;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [2:0]    idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fls = 1'b0;
  logic          iss_rdy = 1'b1;
  logic [D*LW-1:0] lines;
  logic [D-1:0]  clr;
  logic          vld;
  logic [IW-1:0] inst;
  logic [2:0]    idx;
  logic [15:0]   cnt;

  logic [LW-1:0] ln [D];
  exp_t          q [$];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    lines = '0;
    for (int k = 0; k < D; k++) lines[k*LW +: LW] = ln[k];
  end

  isq_iss #(
    .INST_WIDTH (IW),
    .DEPTH      (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fls          (fls),
    .isq_lines_in (lines),
    .clr_val_out  (clr),
    .iss_vld      (vld),
    .iss_rdy      (iss_rdy),
    .iss_inst     (inst),
    .iss_idx      (idx),
    .iss_cnt      (cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk(input logic [IW-1:0] i);
    isq_line_t l;
    l.val  = 1'b1;
    l.wat  = 1'b0;
    l.inst = i;
    return l;
  endfunction

  task automatic push(input logic [IW-1:0] i, input logic [2:0] x);
    exp_t e;
    e.inst = i;
    e.idx  = x;
    q.push_back(e);
  endtask

  // One cycle; the line model clears val where clr was asserted.
  task automatic step();
    logic [D-1:0] c;
    #1 c = clr;
    @(posedge clk);
    #1;
    for (int k = 0; k < D; k++)
      if (c[k]) ln[k][LW-1] = 1'b0;
    @(negedge clk);
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("clr_onehot", 32'($onehot0(clr)), 32'd1);
      for (int k = 0; k < D; k++)
        if (clr[k]) chk("clr_issuable", 32'(ln[k][LW-1:LW-2]), 32'd2);
      if (vld && iss_rdy && !fls) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL iss_extra: got idx %0d want none", idx);
        end else begin
          e = q.pop_front();
          chk("iss_inst", 32'(inst), 32'(e.inst));
          chk("iss_idx", 32'(idx), 32'(e.idx));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < D; k++) ln[k] = '0;
    ln[2] = 16'hbbab;
    ln[5] = 16'hffff;

    // reset with issuable lines present
    @(negedge clk);
    #1 chk("rst_clr", 32'(clr), 32'h00);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    step();
    #1 chk("rst_clr2", 32'(clr), 32'h00);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    for (int k = 0; k < D; k++) ln[k] = '0;
    rst = 1'b0;
    step();

    // single issue
    ln[3] = 16'hbbab;
    push(14'h3bab, 3'd3);
    #1 chk("one_clr", 32'(clr), 32'h08);
    step();
    #1 chk("one_clr_done", 32'(clr), 32'h00);
    chk("one_vld", 32'(vld), 32'd1);
    step();
    #1 chk("one_cnt", 32'(cnt), 32'd1);
    chk("one_idle", 32'(vld), 32'd0);

    // wait bit blocks issue
    ln[5] = 16'hfbab;
    #1 chk("wat_clr", 32'(clr), 32'h00);
    step();
    #1 chk("wat_vld", 32'(vld), 32'd0);
    ln[5] = 16'hbbab;
    push(14'h3bab, 3'd5);
    #1 chk("wat_rel_clr", 32'(clr), 32'h20);
    step();
    step();
    #1 chk("wat_cnt", 32'(cnt), 32'd2);

    // empty flush brings rr_ptr back to 0
    fls = 1'b1;
    step();
    fls = 1'b0;
    #1 chk("fls0_cnt", 32'(cnt), 32'd2);

    // round robin from 0
    ln[1] = mk(14'h0001);
    ln[6] = mk(14'h0006);
    push(14'h0001, 3'd1);
    push(14'h0006, 3'd6);
    #1 chk("rr_a_clr", 32'(clr), 32'h02);
    step();
    #1 chk("rr_b_clr", 32'(clr), 32'h40);
    step();
    #1 chk("rr_c_clr", 32'(clr), 32'h00);
    step();
    #1 chk("rr_cnt", 32'(cnt), 32'd4);
    chk("rr_idle", 32'(vld), 32'd0);

    // move rr_ptr to 2, then 6 wins over 1
    ln[1] = mk(14'h0011);
    push(14'h0011, 3'd1);
    #1 chk("rr2_clr", 32'(clr), 32'h02);
    step();
    ln[1] = mk(14'h0021);
    ln[6] = mk(14'h0026);
    push(14'h0026, 3'd6);
    push(14'h0021, 3'd1);
    #1 chk("rr2_first", 32'(clr), 32'h40);
    step();
    #1 chk("rr2_second", 32'(clr), 32'h02);
    step();
    step();
    #1 chk("rr2_cnt", 32'(cnt), 32'd7);

    // backpressure
    iss_rdy = 1'b0;
    ln[2] = mk(14'h0102);
    push(14'h0102, 3'd2);
    #1 chk("bp_load", 32'(clr), 32'h04);
    step();
    ln[3] = mk(14'h0103);
    ln[4] = mk(14'h0104);
    push(14'h0103, 3'd3);
    push(14'h0104, 3'd4);
    for (int c = 0; c < 4; c++) begin
      #1 chk("bp_clr", 32'(clr), 32'h00);
      chk("bp_vld", 32'(vld), 32'd1);
      chk("bp_inst", 32'(inst), 32'h0102);
      chk("bp_idx", 32'(idx), 32'd2);
      step();
    end
    iss_rdy = 1'b1;
    #1 chk("bp_rel_clr", 32'(clr), 32'h08);
    step();
    #1 chk("bp_b2b_clr", 32'(clr), 32'h10);
    chk("bp_b2b_vld", 32'(vld), 32'd1);
    step();
    #1 chk("bp_last_vld", 32'(vld), 32'd1);
    step();
    #1 chk("bp_cnt", 32'(cnt), 32'd10);
    chk("bp_idle", 32'(vld), 32'd0);

    // flush drops a held entry and restarts scan at 0
    ln[6] = mk(14'h0106);
    #1 chk("fl_load", 32'(clr), 32'h40);
    step();
    fls = 1'b1;
    ln[0] = mk(14'h0100);
    ln[7] = mk(14'h0107);
    #1 chk("fl_clr", 32'(clr), 32'h00);
    chk("fl_inst", 32'(inst), 32'h0106);
    chk("fl_idx", 32'(idx), 32'd6);
    step();
    fls = 1'b0;
    #1 chk("fl_vld", 32'(vld), 32'd0);
    chk("fl_cnt", 32'(cnt), 32'd10);
    push(14'h0100, 3'd0);
    push(14'h0107, 3'd7);
    chk("fl_scan0", 32'(clr), 32'h01);
    step();
    #1 chk("fl_scan7", 32'(clr), 32'h80);
    step();
    step();
    #1 chk("end_vld", 32'(vld), 32'd0);
    chk("end_cnt", 32'(cnt), 32'd12);
    chk("end_q", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
